// File: rtl/cam_capture_rgb332_pkg.sv
// Shared definitions for the OV7670 RGB565 -> RGB332 capture stage:
// FSM encodings, default geometry and RGB565 byte field positions.
package cam_capture_rgb332_pkg;

  localparam int DEF_H_PIX   = 160;
  localparam int DEF_V_LINES = 120;
  localparam int DEF_AW      = 15;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_VBLANK = 2'd1;
  localparam logic [1:0] S_BYTE1  = 2'd2;
  localparam logic [1:0] S_BYTE2  = 2'd3;

  // MSB positions of the fields kept from each RGB565 byte:
  // byte 1 = {R4..R0, G5..G3}, byte 2 = {G2..G0, B4..B0}.
  localparam int B1_R_MSB = 7;
  localparam int B1_G_MSB = 2;
  localparam int B2_B_MSB = 4;

endpackage

// File: rtl/cam_capture_rgb332_px_addr_gen.sv
// Column/row/line-base counters for the frame-buffer write address,
// with clipping to H_PIX x V_LINES and the sticky overflow flag.
module cam_capture_rgb332_px_addr_gen
  import cam_capture_rgb332_pkg::*;
#(
  parameter int H_PIX   = DEF_H_PIX,
  parameter int V_LINES = DEF_V_LINES,
  parameter int AW      = DEF_AW
) (
  input  logic          pl,
  input  logic          Reset_n,
  input  logic          frame_start,
  input  logic          px_done,
  input  logic          line_end,
  output logic [AW-1:0] wr_addr,
  output logic          wr_ok,
  output logic          has_data,
  output logic          overflow
);

  localparam int CW = $clog2(H_PIX + 1);
  localparam int RW = $clog2(V_LINES + 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] line_base;

  // Clipping keeps line_base + col at or below H_PIX*V_LINES-1, so no wrap.
  assign wr_ok    = (col < CW'(H_PIX)) && (row < RW'(V_LINES));
  assign wr_addr  = line_base + AW'(col);
  assign has_data = (row != '0) || (col != '0);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge pl or negedge Reset_n) begin
    if (!Reset_n) begin
      col       <= '0;
      row       <= '0;
      line_base <= '0;
      overflow  <= 1'b0;
    end else if (frame_start) begin
      col       <= '0;
      row       <= '0;
      line_base <= '0;
      overflow  <= 1'b0;
    end else if (px_done) begin
      if (wr_ok) col <= col + CW'(1);
      else       overflow <= 1'b1;
    end else if (line_end && (col != '0)) begin
      // Empty lines (blanking before the first real line) do not count.
      line_base <= line_base + AW'(H_PIX);
      row       <= row + RW'(1);
      col       <= '0;
    end
  end

endmodule

// File: rtl/cam_capture_rgb332.sv
// OV7670 capture: frame/line FSM on registered VSYNC/HREF, RGB565 byte-pair
// assembly into RGB332 and registered frame-buffer write port.
module cam_capture_rgb332
  import cam_capture_rgb332_pkg::*;
#(
  parameter int H_PIX   = DEF_H_PIX,
  parameter int V_LINES = DEF_V_LINES,
  parameter int AW      = DEF_AW
) (
  input  logic          pl,
  input  logic          Reset_n,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] mem_px_addr,
  output logic [7:0]    mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic          overflow
);

  logic [1:0]    state;
  logic [5:0]    rg_q;
  logic          href_q;
  logic          in_frame;
  logic          frame_start;
  logic          px_done;
  logic          line_end;
  logic          wr_ok;
  logic          wr_now;
  logic          has_data;
  logic [AW-1:0] wr_addr;

  assign in_frame    = (state == S_BYTE1) || (state == S_BYTE2);
  assign frame_start = (state == S_VBLANK) && !vsync;
  // A second byte seen together with VSYNC still completes its pixel.
  assign px_done     = (state == S_BYTE2) && href;
  assign line_end    = in_frame && !vsync && href_q && !href;
  assign wr_now      = px_done && wr_ok;

  cam_capture_rgb332_px_addr_gen #(
    .H_PIX   (H_PIX),
    .V_LINES (V_LINES),
    .AW      (AW)
  ) u_addr_gen (
    .pl          (pl),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .px_done     (px_done),
    .line_end    (line_end),
    .wr_addr     (wr_addr),
    .wr_ok       (wr_ok),
    .has_data    (has_data),
    .overflow    (overflow)
  );

  always_ff @(posedge pl or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= S_IDLE;
      rg_q        <= '0;
      href_q      <= 1'b0;
      mem_px_addr <= '0;
      mem_px_data <= '0;
      px_wr       <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      href_q     <= href;
      px_wr      <= wr_now;
      frame_done <= in_frame && vsync && (has_data || wr_now);
      if (wr_now) begin
        mem_px_addr <= wr_addr;
        mem_px_data <= {rg_q, px_data[B2_B_MSB -: 2]};
      end

      case (state)
        S_IDLE:   if (vsync) state <= S_VBLANK;
        S_VBLANK: if (!vsync) state <= S_BYTE1;
        S_BYTE1: begin
          if (vsync) begin
            state <= S_VBLANK;
          end else if (href) begin
            rg_q  <= {px_data[B1_R_MSB -: 3], px_data[B1_G_MSB -: 3]};
            state <= S_BYTE2;
          end
        end
        // Odd byte count: HREF low here drops the half pixel.
        S_BYTE2:  state <= vsync ? S_VBLANK : S_BYTE1;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture_rgb332.sv
// Self-checking bench for cam_capture_rgb332 with a 4x3 pixel buffer:
// table-driven pixel packing plus directed line/clip/frame/reset sequences.
module tb_cam_capture_rgb332;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int AW = 4;

  logic          pl = 1'b0;
  logic          Reset_n;
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic [AW-1:0] mem_px_addr;
  logic [7:0]    mem_px_data;
  logic          px_wr;
  logic          frame_done;
  logic          overflow;

  cam_capture_rgb332 #(.H_PIX(H), .V_LINES(V), .AW(AW)) dut (
    .pl          (pl),
    .Reset_n     (Reset_n),
    .vsync       (vsync),
    .href        (href),
    .px_data     (px_data),
    .mem_px_addr (mem_px_addr),
    .mem_px_data (mem_px_data),
    .px_wr       (px_wr),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  always #5 pl = ~pl;

  typedef struct {
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] exp_px;
  } vec_t;

  vec_t vecs[8];
  int   n_checks = 0;
  int   n_bad    = 0;
  int   wr_addr_q[$];
  int   wr_data_q[$];
  int   exp_a[$];
  int   exp_d[$];
  int   fd_cnt   = 0;
  int   both_cnt = 0;

  // Observe registered outputs half a cycle after the active edge.
  always @(negedge pl) begin
    if (px_wr) begin
      wr_addr_q.push_back(int'(mem_px_addr));
      wr_data_q.push_back(int'(mem_px_data));
      if (frame_done) both_cnt++;
    end
    if (frame_done) fd_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic h, input logic [7:0] d);
    @(negedge pl);
    vsync   = v;
    href    = h;
    px_data = d;
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    exp_a.delete();
    exp_d.delete();
    fd_cnt   = 0;
    both_cnt = 0;
  endtask

  task automatic start_frame();
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_px(input int k);
    cyc(1'b0, 1'b1, vecs[k % 8].b1);
    cyc(1'b0, 1'b1, vecs[k % 8].b2);
  endtask

  task automatic line_gap();
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic end_frame();
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
  endtask

  task automatic expect_px(input int addr, input int k);
    exp_a.push_back(addr);
    exp_d.push_back(int'(vecs[k % 8].exp_px));
  endtask

  task automatic verify_writes(input string name);
    check($sformatf("%s_count", name), wr_addr_q.size(), exp_a.size());
    for (int i = 0; i < exp_a.size(); i++) begin
      if (i < wr_addr_q.size()) begin
        check($sformatf("%s_addr%0d", name, i), wr_addr_q[i], exp_a[i]);
        check($sformatf("%s_data%0d", name, i), wr_data_q[i], exp_d[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // RGB332 = {b1[7:5], b1[2:0], b2[4:3]}, worked out by hand.
    vecs[0] = '{8'hF8, 8'h1F, 8'hE3};
    vecs[1] = '{8'h00, 8'h00, 8'h00};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF};
    vecs[3] = '{8'h07, 8'hE0, 8'h1C};
    vecs[4] = '{8'hA5, 8'h5A, 8'hB7};
    vecs[5] = '{8'h48, 8'h18, 8'h43};
    vecs[6] = '{8'h12, 8'h08, 8'h09};
    vecs[7] = '{8'hE7, 8'h00, 8'hFC};

    Reset_n = 1'b0;
    vsync   = 1'b0;
    href    = 1'b0;
    px_data = 8'h00;
    #12;
    check("rst_addr", 32'(mem_px_addr), 0);
    check("rst_data", 32'(mem_px_data), 0);
    check("rst_wr",   32'(px_wr), 0);
    check("rst_fd",   32'(frame_done), 0);
    check("rst_ovf",  32'(overflow), 0);
    @(negedge pl);
    Reset_n = 1'b1;

    // Pixel packing table: two lines of four pixels.
    clear_mon();
    start_frame();
    for (int k = 0; k < 8; k++) begin
      send_px(k);
      expect_px(k, k);
      if (k % H == H - 1) line_gap();
    end
    end_frame();
    verify_writes("pack");
    check("pack_fd",  fd_cnt, 1);
    check("pack_ovf", 32'(overflow), 0);

    // Three full lines fill the buffer exactly.
    clear_mon();
    start_frame();
    for (int k = 0; k < 3 * H; k++) begin
      send_px(k);
      expect_px(k, k);
      if (k % H == H - 1) line_gap();
    end
    end_frame();
    verify_writes("lines");
    check("lines_fd",        fd_cnt, 1);
    check("lines_ovf",       32'(overflow), 0);
    check("lines_hold_addr", 32'(mem_px_addr), 11);
    check("lines_hold_data", 32'(mem_px_data), 32'h1C);
    check("lines_idle_wr",   32'(px_wr), 0);

    // Six pixels on a four-pixel line, then a short second line.
    clear_mon();
    start_frame();
    for (int k = 0; k < 6; k++) send_px(k);
    line_gap();
    send_px(6);
    send_px(7);
    line_gap();
    end_frame();
    for (int k = 0; k < 4; k++) expect_px(k, k);
    expect_px(4, 6);
    expect_px(5, 7);
    verify_writes("clip");
    check("clip_ovf", 32'(overflow), 1);
    check("clip_fd",  fd_cnt, 1);

    // Three bytes then HREF drops: the trailing half pixel is discarded.
    clear_mon();
    start_frame();
    cyc(1'b0, 1'b1, 8'hF8);
    cyc(1'b0, 1'b1, 8'h1F);
    cyc(1'b0, 1'b1, 8'hAA);
    line_gap();
    send_px(3);
    line_gap();
    end_frame();
    expect_px(0, 0);
    expect_px(H, 3);
    verify_writes("odd");
    check("odd_fd",  fd_cnt, 1);
    check("odd_ovf", 32'(overflow), 0);

    // One line more than the buffer holds.
    clear_mon();
    start_frame();
    for (int k = 0; k < 4 * H; k++) begin
      send_px(k);
      if (k < 3 * H) expect_px(k, k);
      if (k % H == H - 1) line_gap();
    end
    end_frame();
    verify_writes("vlim");
    check("vlim_ovf_sticky", 32'(overflow), 1);
    check("vlim_fd",         fd_cnt, 1);
    clear_mon();
    start_frame();
    cyc(1'b0, 1'b0, 8'h00);
    check("vlim_ovf_cleared", 32'(overflow), 0);
    send_px(0);
    line_gap();
    end_frame();
    expect_px(0, 0);
    verify_writes("vlim_next");

    // VSYNC rises with the final byte: write and frame_done coincide.
    clear_mon();
    start_frame();
    cyc(1'b0, 1'b1, 8'hF8);
    cyc(1'b1, 1'b1, 8'h1F);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    expect_px(0, 0);
    verify_writes("last");
    check("last_fd",   fd_cnt, 1);
    check("last_both", both_cnt, 1);

    // A frame with no pixels produces no frame_done.
    clear_mon();
    start_frame();
    line_gap();
    end_frame();
    check("empty_fd",  fd_cnt, 0);
    check("empty_wrs", wr_addr_q.size(), 0);

    // Asynchronous reset while a write is on the port.
    clear_mon();
    start_frame();
    for (int k = 0; k < 6; k++) send_px(k);
    line_gap();
    send_px(0);
    @(posedge pl);
    #2;
    check("prerst_wr",  32'(px_wr), 1);
    check("prerst_ovf", 32'(overflow), 1);
    Reset_n = 1'b0;
    #1;
    check("midrst_addr", 32'(mem_px_addr), 0);
    check("midrst_data", 32'(mem_px_data), 0);
    check("midrst_wr",   32'(px_wr), 0);
    check("midrst_fd",   32'(frame_done), 0);
    check("midrst_ovf",  32'(overflow), 0);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    Reset_n = 1'b1;
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    check("midrst_no_fd", fd_cnt, 0);
    clear_mon();
    start_frame();
    send_px(4);
    line_gap();
    end_frame();
    expect_px(0, 4);
    verify_writes("postrst");
    check("postrst_fd", fd_cnt, 1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
